drum_step_sequencer: RTL and testbench

Sequences one time step of the drum-mesh column array per audio sample. It holds the columns in reset for memory initialisation, then drives the shared `start_update` level and waits for every column's done flag. It captures the drum-centre displacement and hands it to the audio path over a valid/ready handshake. It sits between the column array and the audio output FIFO, and also reports per-step cycle counts and a stall watchdog.

---
 rtl/drum_step_sequencer.sv | 143 ++++++++++++++
 tb/tb_drum_step_sequencer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/drum_step_sequencer.sv
// drum_step_sequencer
//   Steps the drum-mesh column array once per audio sample. It resets and
//   initialises the columns, raises the shared start_update level, waits for
//   every column to report done, captures the centre displacement and offers
//   it to the audio FIFO over a valid/ready handshake. It also reports step
//   statistics and raises a sticky stall flag when a step runs too long.
//
// Ports
//   clk             single clock
//   reset           synchronous, active-high
//   run             level; enables stepping (sampled in IDLE and WAIT_OUT)
//   reinit          1-cycle pulse; re-initialise all columns
//   col_done        done_update_out of each column
//   center_sample   middle_out of the centre column (signed 1.17)
//   sample_ready    audio FIFO can accept data
//   col_reset       reset to all columns
//   start_update    shared update level to all columns
//   sample_out      captured centre displacement
//   sample_valid    sample_out is valid
//   step_count      completed steps since the last reinit (wraps)
//   cycles_per_step RUN-state cycles of the last completed step
//   stall_err       sticky watchdog flag, cleared only by reset
module drum_step_sequencer #(
  parameter int unsigned NUM_COLS    = 32,
  parameter int unsigned INIT_CYCLES = 1024,
  parameter int unsigned TIMEOUT     = 65535
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  input  logic                reinit,
  input  logic [NUM_COLS-1:0] col_done,
  input  logic signed [17:0]  center_sample,
  input  logic                sample_ready,
  output logic                col_reset,
  output logic                start_update,
  output logic signed [17:0]  sample_out,
  output logic                sample_valid,
  output logic [31:0]         step_count,
  output logic [31:0]         cycles_per_step,
  output logic                stall_err
);

  typedef enum logic [2:0] {
    S_RESET_COLS,
    S_INIT,
    S_IDLE,
    S_RUN,
    S_CAPTURE,
    S_WAIT_OUT
  } state_t;

  localparam logic [31:0] INIT_LAST  = 32'(INIT_CYCLES - 1);
  localparam logic [31:0] TIMEOUT_W  = 32'(TIMEOUT);
  localparam logic [31:0] FIRST_LIVE = 32'd3;

  state_t      state;
  // Shared cycle counter: RESET_COLS length, INIT length, RUN cycle number.
  logic [31:0] cnt;
  logic        all_done;

  assign all_done     = &col_done;
  assign col_reset    = (state == S_RESET_COLS);
  assign start_update = (state == S_RUN);
  assign sample_valid = (state == S_WAIT_OUT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= S_RESET_COLS;
      cnt             <= '0;
      sample_out      <= '0;
      step_count      <= '0;
      cycles_per_step <= '0;
      stall_err       <= 1'b0;
    end else if (reinit && (state != S_RESET_COLS)) begin
      // Overrides completion and transfer; any pending sample is dropped
      // simply by leaving WAIT_OUT.
      state      <= S_RESET_COLS;
      cnt        <= '0;
      step_count <= '0;
    end else begin
      case (state)
        S_RESET_COLS: begin
          if (cnt == 32'd1) begin
            state <= S_INIT;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        S_INIT: begin
          if (cnt == INIT_LAST) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        S_IDLE: begin
          if (run) begin
            state <= S_RUN;
            cnt   <= 32'd1;
          end
        end
        S_RUN: begin
          // Done flags from the previous step linger for the first two RUN
          // cycles, so completion is only qualified from cycle 3 onward.
          // cnt is left untouched on completion so CAPTURE can record it.
          if ((cnt >= FIRST_LIVE) && all_done) begin
            state <= S_CAPTURE;
          end else if (cnt >= TIMEOUT_W) begin
            stall_err <= 1'b1;
            state     <= S_RESET_COLS;
            cnt       <= '0;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        S_CAPTURE: begin
          sample_out      <= center_sample;
          step_count      <= step_count + 32'd1;
          cycles_per_step <= cnt;
          state           <= S_WAIT_OUT;
        end
        S_WAIT_OUT: begin
          if (sample_ready) begin
            if (run) begin
              state <= S_RUN;
              cnt   <= 32'd1;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        default: begin
          state <= S_RESET_COLS;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_drum_step_sequencer.sv
// Directed bench for drum_step_sequencer with NUM_COLS=4, INIT_CYCLES=16,
// TIMEOUT=50. Inputs change 1 ns after a rising edge; outputs are checked
// at the same point, so each check sees the state left by the last edge.
module tb_drum_step_sequencer;

  logic               clk = 1'b0;
  logic               reset;
  logic               run;
  logic               reinit;
  logic [3:0]         col_done;
  logic signed [17:0] center_sample;
  logic               sample_ready;
  logic               col_reset;
  logic               start_update;
  logic signed [17:0] sample_out;
  logic               sample_valid;
  logic [31:0]        step_count;
  logic [31:0]        cycles_per_step;
  logic               stall_err;

  int tests = 0;
  int fails = 0;

  drum_step_sequencer #(
    .NUM_COLS    (4),
    .INIT_CYCLES (16),
    .TIMEOUT     (50)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .run             (run),
    .reinit          (reinit),
    .col_done        (col_done),
    .center_sample   (center_sample),
    .sample_ready    (sample_ready),
    .col_reset       (col_reset),
    .start_update    (start_update),
    .sample_out      (sample_out),
    .sample_valid    (sample_valid),
    .step_count      (step_count),
    .cycles_per_step (cycles_per_step),
    .stall_err       (stall_err)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL time_limit: observed no finish expected finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called in RUN cycle 1. Completion is presented on RUN cycle k; with
  // stale=1 all-ones is also shown on cycles 1 and 2. Returns in CAPTURE.
  task automatic run_step(input int k, input logic [17:0] smp, input bit stale);
    for (int c = 1; c <= k; c++) begin
      col_done      = ((c == k) || (stale && (c <= 2))) ? 4'hF : 4'h0;
      center_sample = smp;
      tick();
      if (c < k) check("start_hold", start_update, 1);
    end
    col_done = 4'h0;
    check("start_drop_capture", start_update, 0);
  endtask

  // Called right after the edge that enters INIT; returns in RUN cycle 1.
  task automatic init_then_run();
    repeat (16) tick();
    check("init_len_idle", start_update, 0);
    tick();
    check("run_entry", start_update, 1);
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; reinit = 1'b0;
    col_done = 4'h0; center_sample = '0; sample_ready = 1'b0;
    repeat (3) tick();
    check("rst_col_reset", col_reset, 1);
    check("rst_start_update", start_update, 0);
    check("rst_sample_valid", sample_valid, 0);
    check("rst_sample_out", sample_out, 0);
    check("rst_step_count", step_count, 0);
    check("rst_cycles_per_step", cycles_per_step, 0);
    check("rst_stall_err", stall_err, 0);

    // Power-up: 2 cycles of col_reset, 16 of INIT, then IDLE -> RUN.
    reset = 1'b0;
    check("col_reset_c1", col_reset, 1);
    tick();
    check("col_reset_c2", col_reset, 1);
    tick();
    check("col_reset_off", col_reset, 0);
    check("init_no_start", start_update, 0);
    run = 1'b1;
    init_then_run();

    // Step 1: done on RUN cycle 20, FIFO ready.
    sample_ready = 1'b1;
    run_step(20, 18'h01234, 1'b0);
    tick();
    check("s1_valid", sample_valid, 1);
    check("s1_sample", sample_out, 32'h01234);
    check("s1_cps", cycles_per_step, 20);
    check("s1_count", step_count, 1);
    tick();
    check("s1_valid_one_cycle", sample_valid, 0);
    check("s1_rerun", start_update, 1);

    // Step 2: stale done on cycles 1-2, real done on 7, FIFO back-pressure.
    sample_ready = 1'b0;
    run_step(7, 18'h0ABCD, 1'b1);
    for (int i = 0; i < 11; i++) begin
      tick();
      check("s2_hold_valid", sample_valid, 1);
      check("s2_hold_sample", sample_out, 32'h0ABCD);
      check("s2_hold_start", start_update, 0);
    end
    sample_ready = 1'b1;
    tick();
    check("s2_xfer_valid", sample_valid, 0);
    check("s2_rerun", start_update, 1);
    check("s2_count", step_count, 2);
    check("s2_cps", cycles_per_step, 7);

    // Step 3: earliest possible completion (cycle 3) behind stale flags.
    run_step(3, 18'h00005, 1'b1);
    tick();
    check("s3_valid", sample_valid, 1);
    check("s3_sample", sample_out, 32'h00005);
    check("s3_cps", cycles_per_step, 3);
    check("s3_count", step_count, 3);
    tick();
    check("s3_rerun", start_update, 1);

    // reinit in the middle of step 4.
    tick();
    reinit = 1'b1;
    tick();
    reinit = 1'b0;
    check("ri_start_drop", start_update, 0);
    check("ri_col_reset", col_reset, 1);
    check("ri_count_clear", step_count, 0);
    check("ri_no_valid", sample_valid, 0);
    tick();
    check("ri_col_reset_c2", col_reset, 1);
    tick();
    check("ri_col_reset_off", col_reset, 0);
    init_then_run();

    // reinit against a pending sample, with ready high the same cycle;
    // reinit held a second cycle lands in RESET_COLS and must be ignored.
    sample_ready = 1'b0;
    run_step(5, 18'h00777, 1'b0);
    tick();
    check("wo_valid", sample_valid, 1);
    check("wo_count", step_count, 1);
    reinit = 1'b1;
    sample_ready = 1'b1;
    tick();
    check("wo_discard", sample_valid, 0);
    check("wo_count_clear", step_count, 0);
    check("wo_col_reset", col_reset, 1);
    tick();
    reinit = 1'b0;
    check("wo_col_reset_c2", col_reset, 1);
    tick();
    check("reinit_ignored_in_reset", col_reset, 0);
    init_then_run();

    // Watchdog: one column never finishes.
    col_done = 4'b0111;
    repeat (49) tick();
    check("wd_cycle50_no_err", stall_err, 0);
    check("wd_cycle50_running", start_update, 1);
    tick();
    check("wd_stall_err", stall_err, 1);
    check("wd_col_reset", col_reset, 1);
    check("wd_start_drop", start_update, 0);
    col_done = 4'h0;
    tick();
    check("wd_col_reset_c2", col_reset, 1);
    tick();
    check("wd_col_reset_off", col_reset, 0);
    init_then_run();
    check("wd_sticky", stall_err, 1);

    // run dropped mid-step: sample still delivered, then park in IDLE.
    run = 1'b0;
    sample_ready = 1'b1;
    run_step(4, 18'h00042, 1'b0);
    tick();
    check("stop_valid", sample_valid, 1);
    check("stop_sample", sample_out, 32'h00042);
    check("stop_count", step_count, 1);
    tick();
    check("stop_valid_drop", sample_valid, 0);
    check("stop_idle", start_update, 0);
    repeat (5) tick();
    check("stop_idle_park", start_update, 0);
    check("stop_sticky", stall_err, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
